fpmul_norm_round: RTL and testbench
===================================

# fpmul_norm_round

Post-multiply normalize-and-round stage of the FP multiplier datapath. Consumes the 22-bit significand product from the Dadda reduction tree plus the sign, pre-biased exponent sum and operand class from the front end. Normalizes and rounds to nearest-even, then handles overflow, underflow and specials. Emits a packed half-precision result through a 2-stage valid/ready pipeline.

## Interface
Parameters:
- MANT_W, 11, significand width including hidden bit; product width is 2*MANT_W
- EXP_W, 5, exponent field width; result width is 1+EXP_W+MANT_W-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  result sign (sa ^ sb)
- in_exp_sum  in  EXP_W+2  signed, ea+eb-bias, biased result exponent before normalization
- in_product  in  2*MANT_W  unsigned significand product, value in [1,4) with 2 integer bits
- in_class  in  2  00 finite, 01 zero, 10 inf, 11 NaN (decided upstream)
- in_nv  in  1  invalid-operation indication from upstream (e.g. inf*0)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  EXP_W+MANT_W  packed {sign, exp, frac}
- out_flags  out  4  {NV, OF, UF, NX}; present only with FPMUL_FLAGS_EN

## Operation
- Stage 1 (normalize): if product[2*MANT_W-1]=1, mant=product[21:11], guard=product[10], sticky=|product[9:0], exp=exp_sum+1; else mant=product[20:10], guard=product[9], sticky=|product[8:0], exp=exp_sum.
- Stage 2 (round/pack): RNE, round_up = guard & (sticky | mant[0]); mant+1 carrying out to 2^MANT_W gives frac=0, exp+1.
- Exponent arithmetic signed, EXP_W+2 bits, no wrap.
- Final exp >= 2^EXP_W-1 -> overflow: result ±inf (exp all ones, frac 0); OF=1, NX=1.
- Final exp <= 0 -> flush to ±0 (no subnormal output); UF=1, NX=1.
- NX = guard|sticky for in-range finite results.
- Class zero -> ±0, flags 0. Class inf -> ±inf, flags 0. Class NaN -> canonical qNaN 0x7E00 (sign 0), NV=in_nv; product/exponent ignored.
- Specials bypass rounding but travel through both stages (fixed latency).

## Timing
- Latency 2 cycles from accepted input to out_valid; throughput 1 beat/cycle when out_ready=1.
- Stage handshake: s2_ready = ~s2_valid | out_ready; s1_ready = ~s1_valid | s2_ready; in_ready = s1_ready. Transfer on valid&ready.
- Stall: out_ready low holds out_result/out_flags stable; at most 2 beats buffered, then in_ready=0.
- Data registers load only on transfer; valid bits clear when drained without refill.
- Reset (async, any time): s1_valid=s2_valid=0, out_valid=0, out_result=0, out_flags=0, in_ready=1 after release; in-flight beats discarded.
- out_valid is never asserted in the cycle following reset release.

## Configuration
- FPMUL_FLAGS_EN defined: out_flags port, flag computation and flag pipeline registers present.
- Undefined: out_flags port absent; result datapath and timing identical.

## Structure
- fpmul_pkg: class enum (FIN, ZERO, INF, NAN), flag struct {nv, of, uf, nx}, MANT_W/EXP_W defaults, QNAN constant 16'h7E00.
- One sub-module: fpmul_rne_round (combinational mant/guard/sticky/exp -> frac, exp, nx, of, uf), instantiated in stage 2.

## Test plan
- 1.0*1.0: product 0x100000, exp_sum 15, FIN -> 0x3C00, flags 0000, out_valid 2 cycles after accept.
- 1.5*1.5: product 0x240000, exp_sum 15 -> 0x4080 (exp 16 via normalize shift), flags 0000.
- RNE: product 0x100200 -> 0x3C00 NX=1 (tie, even LSB); 0x100600 -> 0x3C02 NX=1 (tie, round up).
- Range: product 0x240000, exp_sum 30 -> 0x7C00 OF=1 NX=1; product 0x100000, exp_sum 0, sign 1 -> 0x8000 UF=1 NX=1.
- Specials: class NaN with in_nv=1 -> 0x7E00 NV=1; class inf sign 1 -> 0xFC00 flags 0.
- Backpressure/reset: 4 back-to-back beats, out_ready low 3 cycles -> in_ready drops after 2 accepts, all 4 emerge in order, none lost; rst pulse with 2 beats in flight -> out_valid=0 immediately, no stale output afterward.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared types and defaults for the FP multiplier normalize/round stage.
// FPMUL_FLAGS_EN enables the exception flag path in the modules that import this package.
package fpmul_pkg;

  localparam int MANT_W_DEF = 11;
  localparam int EXP_W_DEF  = 5;

  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    FIN  = 2'b00,
    ZERO = 2'b01,
    INF  = 2'b10,
    NAN  = 2'b11
  } fp_class_e;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

endpackage

// File: rtl/fpmul_rne_round.sv
// Combinational round-to-nearest-even with overflow-to-inf and flush-to-zero.
// Flag output present only with FPMUL_FLAGS_EN.
module fpmul_rne_round
  import fpmul_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic [MANT_W-1:0]        mant_i,
  input  logic                     guard_i,
  input  logic                     sticky_i,
  input  logic signed [EXP_W+2:0]  exp_i,
  output logic [MANT_W-2:0]        frac_o,
  output logic [EXP_W-1:0]         exp_o
`ifdef FPMUL_FLAGS_EN
  ,
  output fp_flags_t                flags_o
`endif
);

  localparam int XE_W = EXP_W + 3;
  localparam logic signed [XE_W-1:0] EXP_MAX  = XE_W'((2 ** EXP_W) - 1);
  localparam logic signed [XE_W-1:0] EXP_ZERO = '0;

  logic                   round_up;
  logic [MANT_W:0]        mant_r;
  logic signed [XE_W-1:0] exp_r;
  logic                   of;
  logic                   uf;
  logic                   hidden_unused;

  assign round_up = guard_i & (sticky_i | mant_i[0]);
  assign mant_r   = {1'b0, mant_i} + {{MANT_W{1'b0}}, round_up};
  // A carry out of the significand leaves the fraction bits zero; only the exponent bumps.
  assign exp_r    = exp_i + $signed({{(XE_W-1){1'b0}}, mant_r[MANT_W]});
  assign of       = (exp_r >= EXP_MAX);
  assign uf       = (exp_r <= EXP_ZERO);
  assign hidden_unused = mant_r[MANT_W-1];

  always_comb begin
    frac_o = mant_r[MANT_W-2:0];
    exp_o  = exp_r[EXP_W-1:0];
    if (of) begin
      frac_o = '0;
      exp_o  = '1;
    end else if (uf) begin
      frac_o = '0;
      exp_o  = '0;
    end
  end

`ifdef FPMUL_FLAGS_EN
  always_comb begin
    flags_o    = '0;
    flags_o.of = of;
    flags_o.uf = uf & ~of;
    flags_o.nx = of | uf | guard_i | sticky_i;
  end
`endif

endmodule

// File: rtl/fpmul_norm_round.sv
// Post-multiply normalize + RNE round + specials, 2-stage valid/ready pipeline.
// Define FPMUL_FLAGS_EN to add the out_flags port {NV, OF, UF, NX} and its pipeline.
module fpmul_norm_round
  import fpmul_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic signed [EXP_W+1:0]   in_exp_sum,
  input  logic [2*MANT_W-1:0]       in_product,
  input  logic [1:0]                in_class,
  input  logic                      in_nv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   out_result
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]                out_flags
`endif
);

  localparam int P_W   = 2 * MANT_W;
  localparam int RES_W = EXP_W + MANT_W;
  localparam int XE_W  = EXP_W + 3;  // room for normalize +1 and round carry +1 without wrap
  localparam logic [RES_W-1:0] QNAN_R = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-2){1'b0}}};

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_ready, s2_ready, s1_load, s2_load;

  logic                   s1_sign_q;
  fp_class_e              s1_cls_q;
  logic [MANT_W-1:0]      s1_mant_q, mant_d;
  logic                   s1_guard_q, guard_d;
  logic                   s1_sticky_q, sticky_d;
  logic signed [XE_W-1:0] s1_exp_q, exp_d;
  logic                   norm_hi;

  logic [MANT_W-2:0]      rnd_frac;
  logic [EXP_W-1:0]       rnd_exp;
  logic [RES_W-1:0]       res_q, res_d;

  assign s2_ready  = ~s2_valid_q | out_ready;
  assign s1_ready  = ~s1_valid_q | s2_ready;
  assign in_ready  = s1_ready;
  assign s1_load   = in_valid & s1_ready;
  assign s2_load   = s1_valid_q & s2_ready;
  assign out_valid = s2_valid_q;
  assign out_result = res_q;

  always_comb begin
    s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
  end

  // Product is in [1,4): the top bit decides whether to shift one extra place.
  assign norm_hi  = in_product[P_W-1];
  assign mant_d   = norm_hi ? in_product[P_W-1 -: MANT_W] : in_product[P_W-2 -: MANT_W];
  assign guard_d  = norm_hi ? in_product[MANT_W-1] : in_product[MANT_W-2];
  assign sticky_d = norm_hi ? (|in_product[MANT_W-2:0]) : (|in_product[MANT_W-3:0]);
  assign exp_d    = XE_W'(in_exp_sum) + {{(XE_W-1){1'b0}}, norm_hi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= FIN;
      s1_mant_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_exp_q    <= '0;
    end else if (s1_load) begin
      s1_sign_q   <= in_sign;
      s1_cls_q    <= fp_class_e'(in_class);
      s1_mant_q   <= mant_d;
      s1_guard_q  <= guard_d;
      s1_sticky_q <= sticky_d;
      s1_exp_q    <= exp_d;
    end
  end

`ifdef FPMUL_FLAGS_EN
  fp_flags_t rnd_flags;
`endif

  fpmul_rne_round #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_round (
    .mant_i   (s1_mant_q),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .exp_i    (s1_exp_q),
    .frac_o   (rnd_frac),
    .exp_o    (rnd_exp)
`ifdef FPMUL_FLAGS_EN
    ,
    .flags_o  (rnd_flags)
`endif
  );

  // Specials skip rounding but still occupy both stages to keep latency fixed.
  always_comb begin
    res_d = {s1_sign_q, rnd_exp, rnd_frac};
    case (s1_cls_q)
      ZERO:    res_d = {s1_sign_q, {(RES_W-1){1'b0}}};
      INF:     res_d = {s1_sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      NAN:     res_d = QNAN_R;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (s2_load) begin
      res_q <= res_d;
    end
  end

`ifdef FPMUL_FLAGS_EN
  logic      s1_nv_q;
  fp_flags_t flags_q, flags_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_nv_q <= 1'b0;
    end else if (s1_load) begin
      s1_nv_q <= in_nv;
    end
  end

  always_comb begin
    flags_d = '0;
    case (s1_cls_q)
      FIN:     flags_d = rnd_flags;
      NAN:     flags_d.nv = s1_nv_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (s2_load) begin
      flags_q <= flags_d;
    end
  end

  assign out_flags = flags_q;
`else
  logic nv_unused;
  assign nv_unused = in_nv;
`endif

endmodule

// File: tb/tb_fpmul_norm_round.sv
// Self-checking bench for fpmul_norm_round: directed vectors, backpressure, reset
// and randomized traffic scored against an arithmetic reference model.
module tb_fpmul_norm_round;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic signed [6:0]  in_exp_sum;
  logic [21:0]        in_product;
  logic [1:0]         in_class;
  logic               in_nv;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_result;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]         out_flags;
`endif

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  fpmul_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_product (in_product),
    .in_class   (in_class),
    .in_nv      (in_nv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef FPMUL_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  // Reference: value-level rounding on the raw product, returns {flags, result}.
  function automatic logic [19:0] ref_model(input logic s, input int es,
                                            input int unsigned p, input logic [1:0] c,
                                            input logic nv);
    int          e;
    int          sh;
    int unsigned q;
    int unsigned rem;
    int unsigned half;
    logic        nx;
    logic [4:0]  e5;
    logic [9:0]  f10;
    if (c == 2'd1) return {4'b0000, s, 15'd0};
    if (c == 2'd2) return {4'b0000, s, 5'h1F, 10'd0};
    if (c == 2'd3) return {nv, 3'b000, 16'h7E00};
    if (p >= 32'h200000) begin
      e  = es + 1;
      sh = 11;
    end else begin
      e  = es;
      sh = 10;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 32'd1 << (sh - 1);
    nx   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {4'b0101, s, 5'h1F, 10'd0};
    if (e <= 0) return {4'b0011, s, 15'd0};
    e5  = e[4:0];
    f10 = q[9:0];
    return {3'b000, nx, s, e5, f10};
  endfunction

  // Scoreboard: push expectation on accept, compare on every output transfer.
  always @(negedge clk) begin
    logic [19:0] ev;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL stale_output observed=%h expected=no_output", out_result);
        end
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          checks++;
          assert (out_result === ev[15:0]) else begin
            failures++;
            $error("FAIL sb_result observed=%h expected=%h", out_result, ev[15:0]);
          end
`ifdef FPMUL_FLAGS_EN
          checks++;
          assert (out_flags === ev[19:16]) else begin
            failures++;
            $error("FAIL sb_flags observed=%b expected=%b", out_flags, ev[19:16]);
          end
`endif
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(in_sign, int'(in_exp_sum), 32'(in_product), in_class, in_nv));
    end
  end

  task automatic drive(input logic s, input int es, input int unsigned p,
                       input logic [1:0] c, input logic nv);
    in_sign    = s;
    in_exp_sum = 7'(es);
    in_product = 22'(p);
    in_class   = c;
    in_nv      = nv;
  endtask

  task automatic directed(input string tag, input logic s, input int es, input int unsigned p,
                          input logic [1:0] c, input logic nv,
                          input logic [15:0] er, input logic [3:0] ef);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(s, es, p, c, nv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (n === 2) else begin
      failures++;
      $error("FAIL %s_latency observed=%0d expected=2", tag, n);
    end
    checks++;
    assert (out_result === er) else begin
      failures++;
      $error("FAIL %s_result observed=%h expected=%h (flags %b)", tag, out_result, er, ef);
    end
`ifdef FPMUL_FLAGS_EN
    checks++;
    assert (out_flags === ef) else begin
      failures++;
      $error("FAIL %s_flags observed=%b expected=%b", tag, out_flags, ef);
    end
`endif
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (n < 20) else begin
      failures++;
      $error("FAIL %s_accept observed=in_ready_low_%0d_cycles expected=accept", tag, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s observed=%0d_pending expected=0_pending", tag, exp_q.size());
    end
  endtask

  initial begin
    logic        pend_acc;
    int unsigned r;
    int unsigned p;
    int          es;
    logic [1:0]  c;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 32'h100000, 2'd0, 1'b0);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      failures++; $error("FAIL rst_out_valid observed=%b expected=0", out_valid);
    end
    checks++;
    assert (out_result === 16'h0000) else begin
      failures++; $error("FAIL rst_out_result observed=%h expected=0000", out_result);
    end
`ifdef FPMUL_FLAGS_EN
    checks++;
    assert (out_flags === 4'b0000) else begin
      failures++; $error("FAIL rst_out_flags observed=%b expected=0000", out_flags);
    end
`endif
    rst = 1'b0;
    checks++;
    assert (in_ready === 1'b1) else begin
      failures++; $error("FAIL rst_in_ready observed=%b expected=1", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      failures++; $error("FAIL post_rst_valid observed=%b expected=0", out_valid);
    end

    // Directed vectors
    directed("one_x_one",   1'b0, 15, 32'h100000, 2'd0, 1'b0, 16'h3C00, 4'b0000);
    directed("norm_shift",  1'b0, 15, 32'h240000, 2'd0, 1'b0, 16'h4080, 4'b0000);
    directed("tie_even",    1'b0, 15, 32'h100200, 2'd0, 1'b0, 16'h3C00, 4'b0001);
    directed("tie_up",      1'b0, 15, 32'h100600, 2'd0, 1'b0, 16'h3C02, 4'b0001);
    directed("round_carry", 1'b0, 15, 32'h1FFE00, 2'd0, 1'b0, 16'h4000, 4'b0001);
    directed("max_exp",     1'b0, 30, 32'h100000, 2'd0, 1'b0, 16'h7800, 4'b0000);
    directed("min_exp",     1'b0,  1, 32'h100000, 2'd0, 1'b0, 16'h0400, 4'b0000);
    directed("overflow",    1'b0, 30, 32'h240000, 2'd0, 1'b0, 16'h7C00, 4'b0101);
    directed("underflow",   1'b1,  0, 32'h100000, 2'd0, 1'b0, 16'h8000, 4'b0011);
    directed("nan_nv",      1'b1,  7, 32'h2ABCDE, 2'd3, 1'b1, 16'h7E00, 4'b1000);
    directed("neg_inf",     1'b1, 15, 32'h180000, 2'd2, 1'b0, 16'hFC00, 4'b0000);
    directed("neg_zero",    1'b1, 40, 32'h3FFFFF, 2'd1, 1'b0, 16'h8000, 4'b0000);

    // Backpressure: out_ready low for 3 cycles while 4 beats are offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b0, 15, 32'h100000, 2'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 15, 32'h240000, 2'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 15, 32'h100600, 2'd0, 1'b0);
    checks++;
    assert (in_ready === 1'b0) else begin
      failures++; $error("FAIL bp_in_ready_a observed=%b expected=0", in_ready);
    end
    checks++;
    assert (out_result === 16'h3C00) else begin
      failures++; $error("FAIL bp_hold_a observed=%h expected=3c00", out_result);
    end
    @(posedge clk); #1;
    checks++;
    assert (in_ready === 1'b0) else begin
      failures++; $error("FAIL bp_in_ready_b observed=%b expected=0", in_ready);
    end
    checks++;
    assert (out_result === 16'h3C00) else begin
      failures++; $error("FAIL bp_hold_b observed=%h expected=3c00", out_result);
    end
    checks++;
    assert (out_valid === 1'b1) else begin
      failures++; $error("FAIL bp_out_valid observed=%b expected=1", out_valid);
    end
    out_ready = 1'b1;
    wait_accept("bp_c");
    drive(1'b0, 15, 32'h1FFE00, 2'd0, 1'b0);
    wait_accept("bp_d");
    drain("bp_drain");

    // Randomized traffic with random backpressure
    pend_acc = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!in_valid || pend_acc) begin
        r = $urandom % 8;
        c = (r < 5) ? 2'd0 : 2'(r - 4);
        p = $urandom_range(32'h3FFFFF, 32'h100000);
        if ($urandom % 4 == 0)
          p = (p & 32'hFFFFF800) | ((($urandom % 2) == 0) ? 32'h400 : 32'h200);
        es = int'($urandom_range(50, 0)) - 15;
        drive(1'($urandom), es, p, c, 1'($urandom));
        in_valid = ($urandom % 4) != 0;
      end
      out_ready = ($urandom % 4) != 0;
      #1 pend_acc = in_valid && in_ready;
    end
    drain("rand_drain");

    // Reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b0, 15, 32'h100000, 2'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 20, 32'h240000, 2'd0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      failures++; $error("FAIL midrst_valid observed=%b expected=0", out_valid);
    end
    checks++;
    assert (out_result === 16'h0000) else begin
      failures++; $error("FAIL midrst_result observed=%h expected=0000", out_result);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    assert (in_ready === 1'b1) else begin
      failures++; $error("FAIL midrst_in_ready observed=%b expected=1", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      assert (out_valid === 1'b0) else begin
        failures++; $error("FAIL midrst_no_stale observed=%b expected=0", out_valid);
      end
    end
    directed("post_rst", 1'b0, 15, 32'h240000, 2'd0, 1'b0, 16'h4080, 4'b0000);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
